// File: rtl/ecc_pkg.sv
// Shared constants, types and helpers for the fetch/decode SECDED boundary.
package ecc_pkg;

  localparam int unsigned CODE_W   = 39;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SYN_W    = 6;
  localparam int unsigned N_PARITY = 6;
  localparam int unsigned CIDX_W   = 6;
  localparam int unsigned DIDX_W   = 5;

  // Hamming parity bit positions inside code[38:1]
  localparam int unsigned PAR_POS [N_PARITY] = '{1, 2, 4, 8, 16, 32};

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    CORR   = 2'd1,
    UNCORR = 2'd2
  } ecc_status_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFETCH = 2'd1,
    FATAL   = 2'd2
  } fsm_state_e;

  // Decoded IF/ID payload
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] pc;
  } beat_t;

  // True when a Hamming position carries a parity bit rather than data
  function automatic logic is_parity_pos(input int unsigned pos);
    logic hit;
    hit = 1'b0;
    for (int unsigned j = 0; j < N_PARITY; j++) begin
      if (pos == PAR_POS[j]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/fetch_decode_ecc_checker_secded.sv
// Combinational (39,32) SECDED decoder: syndrome, single-bit repair, data extraction.
module secded_decoder_39
  import ecc_pkg::*;
(
  input  logic [CODE_W-1:0] code_in,
  output logic [DATA_W-1:0] data_out,
  output ecc_status_e       status
);

  logic [SYN_W-1:0]  syn;
  logic              par;
  logic [CODE_W-1:0] fixed;
  int unsigned       k;

  // Syndrome and overall parity over the received word
  always_comb begin
    syn = '0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (code_in[CIDX_W'(i)]) syn = syn ^ SYN_W'(i);
    end
    par = ^code_in;
  end

  // Classify, repair the flagged position, then gather the data positions
  always_comb begin
    fixed  = code_in;
    status = CLEAN;
    if (par) begin
      if (syn == '0) begin
        status = CORR;
      end else if (syn <= SYN_W'(CODE_W - 1)) begin
        status = CORR;
        for (int unsigned i = 1; i < CODE_W; i++) begin
          if (syn == SYN_W'(i)) fixed[CIDX_W'(i)] = ~code_in[CIDX_W'(i)];
        end
      end else begin
        status = UNCORR;
      end
    end else if (syn != '0) begin
      status = UNCORR;
    end

    data_out = '0;
    k        = 0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (!is_parity_pos(i)) begin
        data_out[DIDX_W'(k)] = fixed[CIDX_W'(i)];
        k = k + 1;
      end
    end
  end

endmodule

// File: rtl/fetch_decode_ecc_checker.sv
// IF/ID pipeline register with SECDED repair, refetch on uncorrectable beats,
// and saturating error counters.
module fetch_decode_ecc_checker
  import ecc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [CODE_W-1:0] InstrD_ECC,
  input  logic [CODE_W-1:0] PCPlus4D_ECC,
  input  logic [CODE_W-1:0] PCD_ECC,
  input  logic              refetch_ack,
  input  logic              clr_counts,
  output logic              valid_out,
  output logic [DATA_W-1:0] InstrD,
  output logic [DATA_W-1:0] PCPlus4D,
  output logic [DATA_W-1:0] PCD,
  output logic              sec_evt,
  output logic              ded_evt,
  output logic              refetch_req,
  output logic [DATA_W-1:0] refetch_pc,
  output logic              fatal_err,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count
);

  fsm_state_e        state;
  logic              s1_valid;
  logic [CODE_W-1:0] s1_instr_code;
  logic [CODE_W-1:0] s1_pc4_code;
  logic [CODE_W-1:0] s1_pc_code;
  beat_t             dec;
  ecc_status_e       st_instr;
  ecc_status_e       st_pc4;
  ecc_status_e       st_pc;

  logic any_uncorr_c;
  logic any_corr_c;
  logic advance_c;
  logic ded_c;
  logic good_c;
  logic pc_ok_c;
  logic pc4_ok_c;

  secded_decoder_39 u_dec_instr (
    .code_in  (s1_instr_code),
    .data_out (dec.instr),
    .status   (st_instr)
  );

  secded_decoder_39 u_dec_pc4 (
    .code_in  (s1_pc4_code),
    .data_out (dec.pc_plus4),
    .status   (st_pc4)
  );

  secded_decoder_39 u_dec_pc (
    .code_in  (s1_pc_code),
    .data_out (dec.pc),
    .status   (st_pc)
  );

  // Beat classification for the S1 -> S2 edge
  always_comb begin
    any_uncorr_c = (st_instr == UNCORR) || (st_pc4 == UNCORR) || (st_pc == UNCORR);
    any_corr_c   = (st_instr == CORR) || (st_pc4 == CORR) || (st_pc == CORR);
    advance_c    = !stall && !flush;
    ded_c        = s1_valid && any_uncorr_c && advance_c && (state == IDLE);
    good_c       = s1_valid && !any_uncorr_c && advance_c && (state == IDLE);
    pc_ok_c      = (st_pc != UNCORR);
    pc4_ok_c     = (st_pc4 != UNCORR);
  end

  // Stage 1: raw codeword capture; an uncorrectable beat is dropped here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid      <= 1'b0;
      s1_instr_code <= '0;
      s1_pc4_code   <= '0;
      s1_pc_code    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      if (valid_in && (state == IDLE) && !ded_c) begin
        s1_valid      <= 1'b1;
        s1_instr_code <= InstrD_ECC;
        s1_pc4_code   <= PCPlus4D_ECC;
        s1_pc_code    <= PCD_ECC;
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: corrected values presented to decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      sec_evt   <= 1'b0;
      InstrD    <= '0;
      PCPlus4D  <= '0;
      PCD       <= '0;
    end else begin
      sec_evt <= 1'b0;
      if (flush) begin
        valid_out <= 1'b0;
      end else if (!stall) begin
        valid_out <= good_c;
        if (good_c) begin
          InstrD   <= dec.instr;
          PCPlus4D <= dec.pc_plus4;
          PCD      <= dec.pc;
          sec_evt  <= any_corr_c;
        end
      end
    end
  end

  // Recovery FSM: refetch from the best trustworthy PC, or give up for good
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ded_evt     <= 1'b0;
      refetch_req <= 1'b0;
      refetch_pc  <= '0;
      fatal_err   <= 1'b0;
    end else begin
      ded_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (ded_c) begin
            ded_evt <= 1'b1;
            if (pc_ok_c) begin
              state       <= REFETCH;
              refetch_req <= 1'b1;
              refetch_pc  <= dec.pc;
            end else if (pc4_ok_c) begin
              state       <= REFETCH;
              refetch_req <= 1'b1;
              refetch_pc  <= dec.pc_plus4 - DATA_W'(4);
            end else begin
              state     <= FATAL;
              fatal_err <= 1'b1;
            end
          end
        end
        REFETCH: begin
          if (refetch_ack) begin
            state       <= IDLE;
            refetch_req <= 1'b0;
          end
        end
        FATAL: begin
          fatal_err <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Saturating error counters; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (clr_counts) begin
      sec_count <= '0;
      ded_count <= '0;
    end else begin
      if (good_c && any_corr_c && (sec_count != '1)) sec_count <= sec_count + CNT_W'(1);
      if (ded_c && (ded_count != '1)) ded_count <= ded_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/fetch_decode_ecc_checker.md
Name: fetch_decode_ecc_checker

Overview:
Decode-side end of the Fetch/Decode ECC boundary. Registers the three 39-bit SECDED codewords (instruction, PC+4, PC) as the IF/ID pipeline register and decodes them. Single-bit errors are corrected; double-bit errors trigger a refetch request. It also keeps saturating error counters. Its outputs drive the decode stage with clean 32-bit values.

Parameters:
CNT_W, 16, width of each saturating error counter
CODE_W, 39, codeword width (fixed; 32 data + 6 Hamming + 1 overall parity)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
valid_in  in  1  fetch-side beat valid
stall  in  1  hold both internal stages
flush  in  1  kill the stage-1 and stage-2 beats
InstrD_ECC  in  39  instruction codeword
PCPlus4D_ECC  in  39  PC+4 codeword
PCD_ECC  in  39  PC codeword
refetch_ack  in  1  PC mux has taken refetch_pc
clr_counts  in  1  synchronous counter clear
valid_out  out  1  decode-stage beat valid
InstrD  out  32  corrected instruction
PCPlus4D  out  32  corrected PC+4
PCD  out  32  corrected PC
sec_evt  out  1  pulse: the output beat had ≥1 corrected field
ded_evt  out  1  pulse: uncorrectable beat detected
refetch_req  out  1  request a refetch from refetch_pc
refetch_pc  out  32  refetch address
fatal_err  out  1  sticky: no trustworthy PC available
sec_count  out  CNT_W  corrected-beat count
ded_count  out  CNT_W  uncorrectable-beat count

Behaviour:
- Codeword layout, identical to hamming_ecc_unit:
  - code[0] is overall even parity over code[38:1].
  - code[1..38] are Hamming positions 1..38. Parity bits sit at positions 1,2,4,8,16,32.
  - Data bits d[0..31] fill the remaining positions in ascending order.
- Decode, per field:
  - s = 6-bit syndrome; p = XOR of all 39 bits.
  - s=0, p=0: clean.
  - p=1, s=0: code[0] flipped; data unchanged; counts as single.
  - p=1, 1≤s≤38: flip position s, then extract data; counts as single.
  - p=1, s>38: uncorrectable.
  - p=0, s≠0: uncorrectable (double).
- Stage 1 (S1): captures the three codewords plus valid when valid_in && !stall && state==IDLE.
- Stage 2 (S2): on !stall, registers the decoded S1 data, valid_out, and sec_evt. Latency from capture to valid_out is 2 clk.
- stall: both stages hold their contents, and the sec_evt/ded_evt pulses are suppressed. stall has no effect on the FSM.
- flush: clears the S1 and S2 valids on the next edge and overrides stall. flush in REFETCH is a no-op.
- An S1 beat with any uncorrectable field does not advance. Instead, on that edge:
  - ded_evt pulses and S1 valid clears.
  - ded_count increments.
  - The FSM transitions as below.
- FSM states are IDLE, REFETCH and FATAL.
  - IDLE→REFETCH: an uncorrectable field is detected and a trustworthy PC exists. refetch_pc is chosen as follows:
    - PCD if PCD decoded clean or corrected;
    - otherwise PCPlus4D−4 if PCPlus4D decoded clean or corrected.
  - IDLE→FATAL: both PC fields are uncorrectable.
  - REFETCH: refetch_req is held high and refetch_pc is held stable. valid_in is ignored and valid_out is 0. On refetch_ack, go to IDLE (refetch_req drops the same edge).
  - FATAL: sticky until rst. fatal_err=1 and valid_out=0.
- Counters:
  - Each saturates at all-ones.
  - sec_count increments once per beat entering S2 with ≥1 corrected field.
  - clr_counts zeroes both counters and wins over a same-cycle increment.
- Reset state (rst=0, async):
  - All valids, pulses, refetch_req and fatal_err are 0.
  - Data outputs, refetch_pc and the counters are 0.
  - FSM is IDLE.
  - Reset mid-REFETCH abandons the request.

Decomposition:
- Shared package ecc_pkg:
  - CODE_W and DATA_W.
  - Parity-position constants.
  - Decode status enum {CLEAN, CORR, UNCORR}.
  - FSM state enum.
- One sub-module, secded_decoder_39: combinational; code_in[38:0] → data_out[31:0], status. Instantiated three times.

Test Plan:
- Encode Instr=0x00500093, PC=0x00000010, PC+4=0x00000014 with no errors, valid_in pulse → 2 clk later valid_out=1 with exact values; sec_evt=0; counters 0.
- Flip InstrD_ECC bit 5 → InstrD=0x00500093, sec_evt=1, sec_count=1. Separately flip bit 0 → same data, sec_count=2.
- Flip InstrD_ECC bits 3 and 9 → ded_evt=1, valid_out stays 0, refetch_req=1, refetch_pc=0x00000010, held for 5 clk; refetch_ack → IDLE next edge, next clean beat passes.
- Double-flip both PCD_ECC and PCPlus4D_ECC → fatal_err=1 and stays 1 with further valid_in; rst low → all outputs 0, IDLE.
- Double-flip PCD_ECC only, PC+4=0x00000014 clean → refetch_pc=0x00000010.
- stall held 3 clk mid-stream → outputs frozen, no duplicate sec_evt. flush with stall → valid_out=0 next edge. Preload sec_count to all-ones (CNT_W=4), inject a single error → count stays 0xF; clr_counts → 0.
